// File: rtl/fp_alu_link_host_if.sv
// fp_alu_link_host_if: command, byte-link and result signals of the FP ALU link host
interface fp_alu_link_host_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [1:0]  cmd_op;
    logic [7:0]  link_data;
    logic        link_valid;
    logic        link_first;
    logic [1:0]  link_op;
    logic [7:0]  link_rdata;
    logic        link_rvalid;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_timeout;
    logic        busy;
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, link_rdata, link_rvalid, res_ready,
        input  cmd_ready, link_data, link_valid, link_first, link_op,
               res_valid, res_data, res_timeout, busy
    );
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, link_rdata, link_rvalid, res_ready,
        output cmd_ready, link_data, link_valid, link_first, link_op,
               res_valid, res_data, res_timeout, busy
    );
endinterface

// File: rtl/fp_alu_link_host.sv
// fp_alu_link_host: serializes an FP ALU command onto the byte link and collects the 4-byte result
module fp_alu_link_host #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input logic               clk,
    input logic               rst,
    fp_alu_link_host_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;
    state_t           state, state_nx;
    logic [31:0]      a_q, b_q, res_q;
    logic [1:0]       op_q;
    logic [2:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic             to_q;
    logic             rx_last, expire;
    logic [63:0]      tx_word;
    logic [7:0]       tx_byte;

    assign rx_last = state == RECV && bus.link_rvalid && idx == 3'd3;
    assign expire  = state == RECV && !bus.link_rvalid && cnt == CNT_W'(TIMEOUT_CYCLES - 1);
    assign tx_word = {a_q, b_q};
    assign tx_byte = tx_word[6'd63 - {idx, 3'd0} -: 8];

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // next-state: a byte arriving on the limit cycle beats the timeout
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.cmd_valid ? SEND : IDLE;
            SEND:    state_nx = idx == 3'd7 ? RECV : SEND;
            RECV:    state_nx = (rx_last || expire) ? DONE : RECV;
            DONE:    state_nx = bus.res_ready ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // outputs decoded from state so reset clears them immediately
    always_comb begin
        bus.cmd_ready   = state == IDLE;
        bus.busy        = state != IDLE;
        bus.link_valid  = state == SEND;
        bus.link_first  = state == SEND && idx == 3'd0;
        bus.link_data   = state == SEND ? tx_byte : 8'd0;
        bus.link_op     = state == IDLE ? 2'd0 : op_q;
        bus.res_valid   = state == DONE;
        bus.res_data    = state == DONE ? res_q : 32'd0;
        bus.res_timeout = state == DONE && to_q;
    end

    // capture, byte index, idle counter and result assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            idx   <= '0;
            cnt   <= '0;
            res_q <= '0;
            to_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        a_q  <= bus.cmd_a;
                        b_q  <= bus.cmd_b;
                        op_q <= bus.cmd_op;
                        idx  <= '0;
                    end
                end
                SEND: begin
                    idx <= idx + 3'd1;
                    if (idx == 3'd7) begin
                        cnt   <= '0;
                        res_q <= '0;
                        to_q  <= 1'b0;
                    end
                end
                RECV: begin
                    if (bus.link_rvalid) begin
                        res_q <= {res_q[23:0], bus.link_rdata};
                        idx   <= idx + 3'd1;
                        cnt   <= '0;
                    end else if (expire) begin
                        res_q <= 32'h7FC0_0000;
                        to_q  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_alu_link_host.sv
// tb_fp_alu_link_host: scoreboard bench for the FP ALU link host
module tb_fp_alu_link_host;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fp_alu_link_host_if bus();
    fp_alu_link_host #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {logic first; logic [7:0] data; logic [1:0] op;} lexp_t;
    typedef struct packed {logic [31:0] data; logic to;} rexp_t;
    lexp_t lq[$];
    rexp_t rq[$];
    lexp_t le;
    rexp_t re;
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int lat, d;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // link monitor: every outbound byte must match the next expected byte
    always @(negedge clk) begin
        if (!rst && bus.link_valid) begin
            if (lq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL link_unexpected: got byte %h expected none", bus.link_data);
            end else begin
                le = lq.pop_front();
                check("link_data", {24'd0, bus.link_data}, {24'd0, le.data});
                check("link_first", {31'd0, bus.link_first}, {31'd0, le.first});
                check("link_op", {30'd0, bus.link_op}, {30'd0, le.op});
                check("cmd_ready_in_send", {31'd0, bus.cmd_ready}, 32'd0);
            end
        end
    end

    // result monitor: each retired result must match the next expected result
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (rq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL res_unexpected: got %h expected none", bus.res_data);
            end else begin
                re = rq.pop_front();
                check("res_data", bus.res_data, re.data);
                check("res_timeout", {31'd0, bus.res_timeout}, {31'd0, re.to});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic [63:0] w;
        logic ok;
        w = {a, b};
        ok = 1'b0;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_op = op;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
        end
        check("cmd_accept", {31'd0, ok}, 32'd1);
        for (int i = 0; i < 8; i++) lq.push_back('{first: (i == 0), data: w[63-8*i -: 8], op: op});
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic send_phase(input logic noise);
        for (int i = 0; i < 8; i++) begin
            bus.link_rvalid = noise;
            bus.link_rdata = noise ? 8'hAA : 8'h00;
            tick();
        end
        bus.link_rvalid = 1'b0;
        bus.link_rdata = 8'h00;
    endtask

    task automatic rx(input logic [7:0] b, input int gap);
        bus.link_rvalid = 1'b0;
        repeat (gap) tick();
        bus.link_rvalid = 1'b1;
        bus.link_rdata = b;
        tick();
        bus.link_rvalid = 1'b0;
    endtask

    task automatic wait_res(output int l);
        l = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                l = cyc - acc_cyc;
                break;
            end
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_op = '0;
        bus.link_rdata = '0;
        bus.link_rvalid = 1'b0;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_link_valid", {31'd0, bus.link_valid}, 32'd0);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_res_data", bus.res_data, 32'd0);
        check("rst_link_op", {30'd0, bus.link_op}, 32'd0);
        rst = 1'b0;
        tick();

        issue(32'h3F80_0000, 32'h4000_0000, 2'd0);
        rq.push_back('{data: 32'h4040_0000, to: 1'b0});
        send_phase(1'b0);
        rx(8'h40, 0);
        rx(8'h40, 3);
        rx(8'h00, 1);
        rx(8'h00, 5);
        wait_res(lat);
        check("lat_gapped", lat, 32'd22);
        tick();

        issue(32'hC0A0_0000, 32'h3F00_0000, 2'd1);
        rq.push_back('{data: 32'h1234_5678, to: 1'b0});
        send_phase(1'b1);
        rx(8'h12, 0);
        rx(8'h34, 0);
        rx(8'h56, 0);
        rx(8'h78, 0);
        wait_res(lat);
        check("lat_zero_gap", lat, 32'd13);
        tick();

        issue(32'h4120_0000, 32'hC120_0000, 2'd2);
        rq.push_back('{data: 32'h7FC0_0000, to: 1'b1});
        send_phase(1'b0);
        rx(8'hAB, 0);
        rx(8'hCD, 0);
        wait_res(lat);
        check("lat_timeout", lat, 32'd19);
        tick();

        bus.res_ready = 1'b0;
        issue(32'h4049_0FDB, 32'h3F80_0000, 2'd3);
        rq.push_back('{data: 32'hDEAD_BEEF, to: 1'b0});
        send_phase(1'b0);
        rx(8'hDE, 0);
        rx(8'hAD, 0);
        rx(8'hBE, 0);
        rx(8'hEF, 0);
        wait_res(lat);
        check("lat_hold", lat, 32'd13);
        tick();
        for (int i = 0; i < 10; i++) begin
            bus.cmd_valid = (i == 3);
            bus.cmd_a = 32'h1111_1111;
            @(negedge clk);
            check("hold_res_valid", {31'd0, bus.res_valid}, 32'd1);
            check("hold_res_data", bus.res_data, 32'hDEAD_BEEF);
            check("hold_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
            tick();
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        d = cyc;
        issue(32'hBF80_0000, 32'h3F80_0000, 2'd0);
        check("accept_after_retire", acc_cyc, d + 1);
        rq.push_back('{data: 32'h3FC0_0000, to: 1'b0});
        send_phase(1'b0);
        rx(8'h3F, 0);
        rx(8'hC0, 0);
        rx(8'h00, 0);
        rx(8'h00, 0);
        wait_res(lat);
        check("lat_after_hold", lat, 32'd13);
        tick();

        issue(32'h1122_3344, 32'h5566_7788, 2'd1);
        repeat (4) tick();
        #2;
        lq.delete();
        rst = 1'b1;
        #1;
        check("arst_link_valid", {31'd0, bus.link_valid}, 32'd0);
        check("arst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);
        check("arst_busy", {31'd0, bus.busy}, 32'd0);
        check("arst_link_op", {30'd0, bus.link_op}, 32'd0);
        check("arst_link_data", {24'd0, bus.link_data}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        issue(32'hAABB_CCDD, 32'h0102_0304, 2'd2);
        rq.push_back('{data: 32'h0102_0304, to: 1'b0});
        send_phase(1'b0);
        rx(8'h01, 0);
        rx(8'h02, 0);
        rx(8'h03, 0);
        rx(8'h04, 0);
        wait_res(lat);
        check("lat_after_reset", lat, 32'd13);
        repeat (3) tick();
        check("link_queue_drained", lq.size(), 32'd0);
        check("res_queue_drained", rq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_alu_link_host.md
Name: fp_alu_link_host

Overview:
- Host-side initiator for the byte-serial link into the 32-bit floating-point ALU tile.
- Accepts one command per transaction over a valid/ready port: operand A, operand B and a 2-bit opcode.
- Serializes the operands onto the 8-bit link, then collects the 4-byte result returned by the ALU.
- Presents the assembled 32-bit result on a valid/ready port. Used by the FPGA and emulation harness that drives the tile.

Parameters:
- TIMEOUT_CYCLES, 255, max idle cycles in RECV before the transaction is aborted. Valid range 1..65535.
- CNT_W, 16, width of the timeout counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  host can accept a command (IDLE only).
- cmd_a  in  32  operand A, IEEE-754 single.
- cmd_b  in  32  operand B, IEEE-754 single.
- cmd_op  in  2  opcode, passed through opaquely.
- link_data  out  8  byte to ALU (drives ui_in).
- link_valid  out  1  link_data valid this cycle.
- link_first  out  1  marks byte 0 of a transaction.
- link_op  out  2  opcode, held for the whole transaction.
- link_rdata  in  8  result byte from ALU (uo_out).
- link_rvalid  in  1  link_rdata valid this cycle.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  32  assembled result.
- res_timeout  out  1  qualifies res_valid: transaction aborted.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, SEND, RECV, DONE.
- Reset (async, any state, mid-transaction included):
  - State goes to IDLE.
  - All outputs 0 except cmd_ready=1.
  - Capture registers, byte index and counter are cleared.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, capture a, b and op, then go to SEND next cycle.
- SEND:
  - 8 consecutive cycles, one byte per cycle, link_valid=1.
  - Byte order by index 0..7: A[31:24], A[23:16], A[15:8], A[7:0], B[31:24], B[23:16], B[15:8], B[7:0].
  - link_first=1 on index 0 only.
  - No backpressure on the outbound link.
  - link_rvalid is ignored in SEND.
  - After index 7, go to RECV. Clear the counter and rx index.
- RECV:
  - link_valid=0.
  - Each cycle with link_rvalid=1 shifts link_rdata in, MSB byte first, and resets the counter.
  - The 4th byte moves the state to DONE next cycle with res_timeout=0.
  - Counter increments on cycles without link_rvalid. When it equals TIMEOUT_CYCLES, go to DONE with res_timeout=1 and res_data=32'h7FC00000 (canonical qNaN). Partial bytes are discarded.
  - link_rvalid on the same cycle the counter hits the limit: the byte wins, the counter clears and there is no timeout.
- DONE:
  - res_valid=1, with res_data and res_timeout held stable until res_ready.
  - On res_valid&&res_ready, go to IDLE next cycle and deassert res_valid.
  - link_rvalid is ignored.
- No overlap between transactions:
  - cmd_valid asserted during DONE is accepted no earlier than the first IDLE cycle.
  - res_ready and cmd_valid high together in DONE: the result retires this cycle and the command is accepted next cycle.
- link_op and the captured operands stay stable from SEND through DONE. link_op is 0 in IDLE.
- Latency with a zero-gap ALU:
  - Command accepted at cycle 0.
  - Bytes drive cycles 1–8.
  - rvalid on cycles 9–12.
  - res_valid at cycle 13.
- Throughput: at best one transaction per 14 cycles.

Test Plan:
- Reset, then cmd a=3F800000 b=40000000 op=00 -> link bytes 3F,80,00,00,40,00,00,00 on cycles 1–8. link_first only on the 3F byte. link_op=00 throughout. cmd_ready=0 from cycle 1.
- After SEND, rvalid bytes 40,40,00,00 with gaps of 0, 3, 1 and 5 cycles -> res_data=40400000, res_timeout=0, res_valid asserted the cycle after the last byte.
- TIMEOUT_CYCLES=8, two rx bytes then silence -> res_valid with res_timeout=1 and res_data=7FC00000 exactly 8 idle cycles after the last byte.
- Hold res_ready=0 for 10 cycles in DONE -> res_valid and res_data stable. A cmd_valid pulse in that window is not accepted (cmd_ready=0). Raising res_ready returns the block to IDLE and the next command is accepted.
- Assert rst at SEND index 4 -> outputs clear immediately (async). A subsequent command restarts at byte index 0 with link_first=1.
- link_rvalid=1 with data AA throughout SEND -> ignored. The result is assembled only from bytes arriving in RECV.
